// File: rtl/joystick_mouse_emu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : joystick_mouse_axis                                           |
// | Purpose  : One mouse axis. Turns a debounced direction request into a    |
// |            steady stream of 2-bit Gray (quadrature) steps with an        |
// |            optional step-period acceleration.                            |
// | Ports    : clk, rst_n    clock / asynchronous active-low reset           |
// |            dir_pos      request +1 steps (mutually exclusive w/ dir_neg) |
// |            dir_neg      request -1 steps                                 |
// |            phase        quadrature phases {B,A}                          |
// |            move_next    axis will be in MOVE after this clock            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module joystick_mouse_axis #(
  parameter int  CNT_W       = 20,
  parameter int  STEP_SLOW   = 524288,
  parameter int  STEP_FAST   = 65536,
  parameter int  ACCEL_STEPS = 8,
  parameter bit  ACCEL_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dir_pos,
  input  logic       dir_neg,
  output logic [1:0] phase,
  output logic       move_next
);

  localparam int CS_W = $clog2(ACCEL_STEPS + 1);

  localparam logic [CNT_W-1:0] SLOW_P = CNT_W'(STEP_SLOW);
  localparam logic [CNT_W-1:0] FAST_P = CNT_W'(STEP_FAST);
  localparam logic [CS_W-1:0]  ACC_N  = CS_W'(ACCEL_STEPS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MOVE = 1'b1
  } axis_state_t;

  axis_state_t      state,    state_nx;
  logic [CNT_W-1:0] timer,    timer_nx;
  logic [CNT_W-1:0] period,   period_nx;
  logic [CS_W-1:0]  count,    count_nx;
  logic [1:0]       phase_nx;
  logic             move_neg, move_neg_nx;

  logic             want;
  logic             take_step;
  logic             restart;
  logic [CNT_W-1:0] base_period;
  logic [CNT_W-1:0] half_period;
  logic [CS_W-1:0]  base_count;
  logic [CS_W-1:0]  count_inc;

  assign want = dir_pos | dir_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      period   <= SLOW_P;
      count    <= '0;
      phase    <= 2'b00;
      move_neg <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      period   <= period_nx;
      count    <= count_nx;
      phase    <= phase_nx;
      move_neg <= move_neg_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    period_nx   = period;
    count_nx    = count;
    phase_nx    = phase;
    move_neg_nx = move_neg;
    take_step   = 1'b0;
    restart     = 1'b0;
    base_period = period;
    half_period = period >> 1;
    base_count  = count;
    count_inc   = count + 1'b1;

    case (state)
      IDLE: begin
        if (want) begin
          state_nx  = MOVE;
          take_step = 1'b1;
          restart   = 1'b1;
        end
      end
      MOVE: begin
        if (!want) begin
          // Phase is deliberately left where it is.
          state_nx  = IDLE;
          period_nx = SLOW_P;
          count_nx  = '0;
        end else if (dir_neg != move_neg) begin
          // Reversal within one clock behaves exactly like a fresh press.
          take_step = 1'b1;
          restart   = 1'b1;
        end else if (timer == '0) begin
          take_step = 1'b1;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (take_step) begin
      base_period = restart ? SLOW_P : period;
      base_count  = restart ? '0 : count;
      count_inc   = base_count + 1'b1;
      half_period = base_period >> 1;
      // The period picked here is what the timer reloads with, so a halving
      // takes effect on the interval that starts with this step.
      if (ACCEL_EN && (count_inc >= ACC_N)) begin
        period_nx = (half_period < FAST_P) ? FAST_P : half_period;
        count_nx  = '0;
      end else begin
        period_nx = base_period;
        count_nx  = count_inc;
      end
      timer_nx    = period_nx - 1'b1;
      // Gray walk on {B,A}: +1 is 00->01->11->10, -1 is the reverse.
      phase_nx    = dir_neg ? {~phase[0], phase[1]} : {phase[0], ~phase[1]};
      move_neg_nx = dir_neg;
    end
  end

  assign move_next = (state_nx == MOVE);

endmodule

// +--------------------------------------------------------------------------+
// | Module   : joystick_mouse_emu                                            |
// | Purpose  : Converts raw active-low joystick pins into Atari ST mouse     |
// |            quadrature phases plus fire. Each pin is synchronised and     |
// |            debounced; each axis steps at a steady (optionally            |
// |            accelerating) rate while a direction is held.                 |
// | Config   : define JOYMOUSE_ACCEL_EN to enable step-period acceleration.  |
// | Ports    : clk_32   in  1  system clock                                  |
// |            reset_n  in  1  asynchronous active-low reset                 |
// |            io_n     in  5  raw pins, active low:                         |
// |                            [0] fire [1] right [2] left [3] down [4] up   |
// |            fire     out 1  debounced fire, active high                   |
// |            mouse_x  out 2  X quadrature {B,A}                            |
// |            mouse_y  out 2  Y quadrature {B,A}                            |
// |            moving   out 1  either axis in MOVE                           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module joystick_mouse_emu #(
  parameter int CNT_W        = 20,
  parameter int DEBOUNCE_CYC = 32000,
  parameter int STEP_SLOW    = 524288,
  parameter int STEP_FAST    = 65536,
  parameter int ACCEL_STEPS  = 8
) (
  input  logic       clk_32,
  input  logic       reset_n,
  input  logic [4:0] io_n,
  output logic       fire,
  output logic [1:0] mouse_x,
  output logic [1:0] mouse_y,
  output logic       moving
);

`ifdef JOYMOUSE_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [4:0] sync_1;
  logic [4:0] sync_2;
  logic [4:0] deb;

  logic x_pos, x_neg, y_pos, y_neg;
  logic x_move_next, y_move_next;

  // Two-flop synchroniser; inversion makes everything downstream active high.
  always_ff @(posedge clk_32 or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 5'b00000;
      sync_2 <= 5'b00000;
    end else begin
      sync_1 <= ~io_n;
      sync_2 <= sync_1;
    end
  end

  // Per-pin debounce: the counter only runs while the synced level disagrees
  // with the debounced level, so any bounce back restarts the qualification.
  for (genvar p = 0; p < 5; p++) begin : g_debounce
    logic [DB_W-1:0] cnt;
    logic            level;

    always_ff @(posedge clk_32 or negedge reset_n) begin
      if (!reset_n) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync_2[p] == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt   <= '0;
        level <= sync_2[p];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign deb[p] = level;
  end

  // Opposing directions pressed together cancel to "no request".
  assign x_pos = deb[1] & ~deb[2];
  assign x_neg = deb[2] & ~deb[1];
  assign y_pos = deb[3] & ~deb[4];
  assign y_neg = deb[4] & ~deb[3];

  joystick_mouse_axis #(
    .CNT_W       (CNT_W),
    .STEP_SLOW   (STEP_SLOW),
    .STEP_FAST   (STEP_FAST),
    .ACCEL_STEPS (ACCEL_STEPS),
    .ACCEL_EN    (ACCEL_ON)
  ) u_axis_x (
    .clk       (clk_32),
    .rst_n     (reset_n),
    .dir_pos   (x_pos),
    .dir_neg   (x_neg),
    .phase     (mouse_x),
    .move_next (x_move_next)
  );

  joystick_mouse_axis #(
    .CNT_W       (CNT_W),
    .STEP_SLOW   (STEP_SLOW),
    .STEP_FAST   (STEP_FAST),
    .ACCEL_STEPS (ACCEL_STEPS),
    .ACCEL_EN    (ACCEL_ON)
  ) u_axis_y (
    .clk       (clk_32),
    .rst_n     (reset_n),
    .dir_pos   (y_pos),
    .dir_neg   (y_neg),
    .phase     (mouse_y),
    .move_next (y_move_next)
  );

  // Registered from the axes' next states so it lines up with their state.
  always_ff @(posedge clk_32 or negedge reset_n) begin
    if (!reset_n) begin
      moving <= 1'b0;
    end else begin
      moving <= x_move_next | y_move_next;
    end
  end

  assign fire = deb[0];

endmodule
`default_nettype wire
